// File: rtl/me_pkg.sv
// Shared motion-estimation constants and the reference feeder state encoding.
package me_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PREFILL = 3'd1,
      ST_SYNC    = 3'd2,
      ST_STREAM  = 3'd3,
      ST_ABORT   = 3'd4,
      ST_DONE    = 3'd5
   } feed_state_e;

   localparam int unsigned DEF_ROW_WORDS  = 35;
   localparam int unsigned DEF_NUM_ROWS   = 16;
   localparam int unsigned DEF_ROW_STRIDE = 120;
   localparam int unsigned DEF_FIFO_DEPTH = 8;
   localparam int unsigned WORD_W         = 64;

endpackage

// File: rtl/ref_fifo.sv
// Synchronous word FIFO with flush; head is visible combinationally for same-cycle pop.
module ref_fifo
   import me_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned W     = WORD_W
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [W-1:0]               wdata_i,
   input  logic                       pop_i,
   output logic [W-1:0]               head_c_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(DEPTH + 1);

   logic [W-1:0]    mem_q [DEPTH];
   logic [PW-1:0]   wr_q;
   logic [PW-1:0]   rd_q;
   logic [CNTW-1:0] cnt_q;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= bump(wr_q);
         if (pop_i)  rd_q <= bump(rd_q);
         cnt_q <= cnt_q + CNTW'(push_i) - CNTW'(pop_i);
      end
   end

   // Storage carries no reset; only slots below count are ever read.
   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
   end

   assign head_c_o = mem_q[rd_q];
   assign count_o  = cnt_q;

endmodule

// File: rtl/ref_feeder.sv
// Fetches one search line of reference rows from memory and streams it gap-free
// to the reference buffer after a one-cycle next_line resync pulse.
module ref_feeder
   import me_pkg::*;
#(
   parameter int unsigned AW          = 20,
   parameter int unsigned ROW_WORDS   = DEF_ROW_WORDS,
   parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS,
   parameter int unsigned ROW_STRIDE  = DEF_ROW_STRIDE,
   parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int unsigned START_LEVEL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     base_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic [AW-1:0]     mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [WORD_W-1:0] ref_word,
   output logic              next_line
);

   localparam int unsigned TOTAL = NUM_ROWS * ROW_WORDS;
   localparam int unsigned TW    = $clog2(TOTAL + 1);
   localparam int unsigned OW    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW    = OW + 1;
   localparam int unsigned CW    = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

   feed_state_e       state_q, state_d;
   logic [AW-1:0]     row_addr_q, row_addr_d;
   logic [CW-1:0]     col_q, col_d;
   logic [TW-1:0]     issued_q, issued_d;
   logic [TW-1:0]     popped_q, popped_d;
   logic [OW-1:0]     outst_q, outst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              mem_req_q, mem_req_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] ref_word_q, ref_word_d;
   logic              next_line_q, next_line_d;

   logic              grant;
   logic              rsp_ok;
   logic              start_ok;
   logic              pop_req;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_clear;
   logic [WORD_W-1:0] fifo_head;
   logic [OW-1:0]     fifo_cnt;
   logic [OW-1:0]     cnt_nxt;

   // Handshake and FIFO control; stray responses with nothing outstanding are dropped.
   assign grant      = mem_req_q & mem_gnt;
   assign rsp_ok     = mem_rvalid & (outst_q != '0);
   assign start_ok   = (state_q == ST_IDLE) & start;
   assign pop_req    = (state_q == ST_SYNC) | (state_q == ST_STREAM);
   assign fifo_pop   = pop_req & (fifo_cnt != '0);
   assign fifo_push  = rsp_ok & (state_q != ST_ABORT);
   assign fifo_clear = (state_q == ST_ABORT) | start_ok;

   ref_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (WORD_W)
   ) u_fifo (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (fifo_clear),
      .push_i   (fifo_push),
      .wdata_i  (mem_rdata),
      .pop_i    (fifo_pop),
      .head_c_o (fifo_head),
      .count_o  (fifo_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         row_addr_q  <= '0;
         col_q       <= '0;
         issued_q    <= '0;
         popped_q    <= '0;
         outst_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         ref_word_q  <= '0;
         next_line_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_addr_q  <= row_addr_d;
         col_q       <= col_d;
         issued_q    <= issued_d;
         popped_q    <= popped_d;
         outst_q     <= outst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         ref_word_q  <= ref_word_d;
         next_line_q <= next_line_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      row_addr_d = row_addr_q;
      col_d      = col_q;
      issued_d   = issued_q + TW'(grant);
      popped_d   = popped_q + TW'(fifo_pop);
      outst_d    = outst_q + OW'(grant) - OW'(rsp_ok);
      err_d      = err_q;
      ref_word_d = '0;

      // Raster walk: the row base advances by the stride, the column within a row.
      if (grant) begin
         if (col_q == CW'(ROW_WORDS - 1)) begin
            col_d      = '0;
            row_addr_d = row_addr_q + AW'(ROW_STRIDE);
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_PREFILL;
               row_addr_d = base_addr;
               col_d      = '0;
               issued_d   = '0;
               popped_d   = '0;
               err_d      = 1'b0;
            end
         end
         ST_PREFILL: begin
            if ((fifo_cnt >= OW'(START_LEVEL)) ||
                ((issued_q == TW'(TOTAL)) && (outst_q == '0))) begin
               state_d = ST_SYNC;
            end
         end
         ST_SYNC, ST_STREAM: begin
            if (fifo_cnt == '0) begin
               err_d   = 1'b1;
               state_d = ST_ABORT;
            end else begin
               ref_word_d = fifo_head;
               if (popped_q == TW'(TOTAL - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         ST_ABORT: begin
            if (outst_q == '0) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cnt_nxt = fifo_clear ? '0 : fifo_cnt + OW'(fifo_push) - OW'(fifo_pop);

      // Credit check counts words in flight plus buffered words so the FIFO cannot overflow.
      mem_req_d   = (state_d inside {ST_PREFILL, ST_SYNC, ST_STREAM}) &&
                    (issued_d < TW'(TOTAL)) &&
                    ((SW'(outst_d) + SW'(cnt_nxt)) < SW'(FIFO_DEPTH));
      mem_addr_d  = mem_req_d ? (row_addr_d + AW'(col_d)) : '0;
      busy_d      = state_d inside {ST_PREFILL, ST_SYNC, ST_STREAM, ST_ABORT};
      done_d      = (state_d == ST_DONE);
      next_line_d = (state_d == ST_SYNC);
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign ref_word  = ref_word_q;
   assign next_line = next_line_q;

endmodule
